// File: rtl/attr_interp_unit.sv
// attr_interp_unit: barycentric attribute interpolator for pixel quads.
// Two pipeline stages (weighted products, then sum/round/saturate) feed a
// circular output FIFO. Fully-masked quads can be discarded after the pipeline.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds valid and payload stable until that edge, and ready
// never depends combinationally on valid. in_ready is a credit computed only
// from local state, so every accepted quad is guaranteed a FIFO slot.
module attr_interp_unit #(
  parameter int Q_DEPTH    = 4,
  parameter int NUM_ATTR   = 4,
  parameter int ATTR_W     = 32,
  parameter int BARY_W     = 17,
  parameter int W_FRAC     = 16,
  parameter int DROP_EMPTY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_x,
  input  logic [15:0]                  in_y,
  input  logic [3:0]                   in_mask,
  input  logic [BARY_W-1:0]            in_w0,
  input  logic [BARY_W-1:0]            in_w1,
  input  logic [BARY_W-1:0]            in_w2,
  input  logic [NUM_ATTR*ATTR_W-1:0]   in_a0,
  input  logic [NUM_ATTR*ATTR_W-1:0]   in_a1,
  input  logic [NUM_ATTR*ATTR_W-1:0]   in_a2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_x,
  output logic [15:0]                  out_y,
  output logic [3:0]                   out_mask,
  output logic [NUM_ATTR*ATTR_W-1:0]   out_attr,
  output logic [$clog2(Q_DEPTH+1)-1:0] level,
  output logic                         busy
);

  localparam int LW    = $clog2(Q_DEPTH + 1);
  localparam int AW    = NUM_ATTR * ATTR_W;
  localparam int PW    = ATTR_W + BARY_W + 1;
  localparam int SW    = PW + 2;
  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  localparam logic signed [SW-1:0] RND     = SW'(1) <<< (W_FRAC - 1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ATTR_W+1){1'b0}}, {(ATTR_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-ATTR_W+1){1'b1}}, {(ATTR_W-1){1'b0}}};

  // stage S1: weighted products
  logic                   s1_v;
  logic [15:0]            s1_x, s1_y;
  logic [3:0]             s1_mask;
  logic [NUM_ATTR*PW-1:0] s1_p0, s1_p1, s1_p2;

  // stage S2: rounded, saturated attributes
  logic                   s2_v;
  logic [15:0]            s2_x, s2_y;
  logic [3:0]             s2_mask;
  logic [AW-1:0]          s2_attr;
  logic [AW-1:0]          s2_next;
  logic signed [SW-1:0]   sum_c [NUM_ATTR];
  logic signed [SW-1:0]   shr_c [NUM_ATTR];

  // output FIFO
  logic [15:0]            mem_x    [Q_DEPTH];
  logic [15:0]            mem_y    [Q_DEPTH];
  logic [3:0]             mem_mask [Q_DEPTH];
  logic [AW-1:0]          mem_attr [Q_DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [LW-1:0]          count;

  logic [LW:0]            occ;
  logic                   accept, keep, wr, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit counts every quad in flight so a FIFO slot is always reserved.
  assign occ      = {1'b0, count} + {{LW{1'b0}}, s1_v} + {{LW{1'b0}}, s2_v};
  assign in_ready = !rst && !flush && (occ < (LW+1)'(Q_DEPTH));
  assign accept   = in_valid && in_ready;
  assign keep     = (DROP_EMPTY == 0) || (s2_mask != 4'b0000);
  assign wr       = s2_v && keep && !flush;
  assign pop      = out_valid && out_ready && !flush;

  assign out_valid = (count != '0);
  assign out_x     = mem_x[head];
  assign out_y     = mem_y[head];
  assign out_mask  = mem_mask[head];
  assign out_attr  = mem_attr[head];
  assign level     = count;
  assign busy      = s1_v | s2_v | (count != '0);

  // S1 register: capture quad and per-channel signed products on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_mask <= '0;
      s1_p0   <= '0;
      s1_p1   <= '0;
      s1_p2   <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_x    <= in_x;
        s1_y    <= in_y;
        s1_mask <= in_mask;
        for (int k = 0; k < NUM_ATTR; k++) begin
          s1_p0[k*PW +: PW] <= PW'($signed(in_a0[k*ATTR_W +: ATTR_W])) * PW'($signed({1'b0, in_w0}));
          s1_p1[k*PW +: PW] <= PW'($signed(in_a1[k*ATTR_W +: ATTR_W])) * PW'($signed({1'b0, in_w1}));
          s1_p2[k*PW +: PW] <= PW'($signed(in_a2[k*ATTR_W +: ATTR_W])) * PW'($signed({1'b0, in_w2}));
        end
      end
    end
  end

  // S2 datapath: sum with guard bits, round half up, arithmetic shift, saturate
  always_comb begin
    s2_next = '0;
    for (int k = 0; k < NUM_ATTR; k++) begin
      sum_c[k] = $signed({{2{s1_p0[k*PW+PW-1]}}, s1_p0[k*PW +: PW]})
               + $signed({{2{s1_p1[k*PW+PW-1]}}, s1_p1[k*PW +: PW]})
               + $signed({{2{s1_p2[k*PW+PW-1]}}, s1_p2[k*PW +: PW]});
      shr_c[k] = (sum_c[k] + RND) >>> W_FRAC;
      if (shr_c[k] > SAT_MAX)
        s2_next[k*ATTR_W +: ATTR_W] = {1'b0, {(ATTR_W-1){1'b1}}};
      else if (shr_c[k] < SAT_MIN)
        s2_next[k*ATTR_W +: ATTR_W] = {1'b1, {(ATTR_W-1){1'b0}}};
      else
        s2_next[k*ATTR_W +: ATTR_W] = shr_c[k][ATTR_W-1:0];
    end
  end

  // S2 register: hold the finished quad until it is written to the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_mask <= '0;
      s2_attr <= '0;
    end else begin
      s2_v <= s1_v && !flush;
      if (s1_v) begin
        s2_x    <= s1_x;
        s2_y    <= s1_y;
        s2_mask <= s1_mask;
        s2_attr <= s2_next;
      end
    end
  end

  // FIFO: circular storage; flush drops pointers/count but leaves data alone
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        mem_x[i]    <= '0;
        mem_y[i]    <= '0;
        mem_mask[i] <= '0;
        mem_attr[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem_x[tail]    <= s2_x;
        mem_y[tail]    <= s2_y;
        mem_mask[tail] <= s2_mask;
        mem_attr[tail] <= s2_attr;
        tail           <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({wr, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_write_full: assert property (@(posedge clk) disable iff (rst) !(wr && count == LW'(Q_DEPTH)));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));

endmodule

// File: tb/tb_attr_interp_unit.sv
// Bench for attr_interp_unit: directed cases plus a randomized stream,
// checked through an expected-result queue filled at accept time.
module tb_attr_interp_unit;

  localparam int QD = 4;
  localparam int NA = 4;
  localparam int AW = 32;
  localparam int BW = 17;
  localparam int WF = 16;
  localparam int DW = NA * AW;
  localparam int LW = $clog2(QD + 1);
  localparam int EW = 36 + DW;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid, busy;
  logic [15:0]   in_x, in_y, out_x, out_y;
  logic [3:0]    in_mask, out_mask;
  logic [BW-1:0] in_w0, in_w1, in_w2;
  logic [DW-1:0] in_a0, in_a1, in_a2, out_attr;
  logic [LW-1:0] level;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int n_out = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rnd_on = 0;

  attr_interp_unit #(
    .Q_DEPTH(QD), .NUM_ATTR(NA), .ATTR_W(AW), .BARY_W(BW), .W_FRAC(WF), .DROP_EMPTY(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mask(in_mask),
    .in_w0(in_w0), .in_w1(in_w1), .in_w2(in_w2),
    .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_mask(out_mask), .out_attr(out_attr),
    .level(level), .busy(busy)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference interpolation, saturating to the signed 32-bit range
  function automatic logic [EW-1:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [3:0] m,
                                          input logic [BW-1:0] w0, input logic [BW-1:0] w1,
                                          input logic [BW-1:0] w2,
                                          input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                          input logic [DW-1:0] a2);
    logic [DW-1:0] r;
    longint s, q;
    r = '0;
    for (int k = 0; k < NA; k++) begin
      s = longint'($signed(a0[k*AW +: AW])) * longint'(w0)
        + longint'($signed(a1[k*AW +: AW])) * longint'(w1)
        + longint'($signed(a2[k*AW +: AW])) * longint'(w2);
      q = (s + (longint'(1) <<< (WF - 1))) >>> WF;
      if (q > 64'sd2147483647) q = 64'sd2147483647;
      if (q < -64'sd2147483648) q = -64'sd2147483648;
      r[k*AW +: AW] = q[31:0];
    end
    return {x, y, m, r};
  endfunction

  // driver: offer one quad, push its expected result when it is accepted
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] m,
                      input logic [BW-1:0] w0, input logic [BW-1:0] w1, input logic [BW-1:0] w2,
                      input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2);
    bit ok;
    in_x = x; in_y = y; in_mask = m;
    in_w0 = w0; in_w1 = w1; in_w2 = w2;
    in_a0 = a0; in_a1 = a1; in_a2 = a2;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk_eq("accept_timeout", 0, 1);
    else begin
      last_acc = cyc;
      if (m != 4'b0000) exp_q.push_back(model(x, y, m, w0, w1, w2, a0, a1, a2));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
         BW'($urandom_range(0, 131071)), BW'($urandom_range(0, 131071)),
         BW'($urandom_range(0, 131071)),
         {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
         {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk_eq("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare each popped head against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk_eq("spurious_out", 1, 0);
      else chk_eq("out_data", {out_x, out_y, out_mask, out_attr}, exp_q.pop_front());
      n_out++;
    end
  end

  // background consumer that stalls at random during the stream phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n0, extra, lat;
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_mask = '0;
    in_w0 = '0; in_w1 = '0; in_w2 = '0;
    in_a0 = '0; in_a1 = '0; in_a2 = '0;

    // power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", in_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_level", level, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_out_word", {out_x, out_y, out_mask, out_attr}, 0);
    chk_eq("rst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // identity weights and 3-cycle latency
    out_ready = 1'b1;
    send(16'd10, 16'd20, 4'hF, 17'h10000, 17'h0, 17'h0,
         {32'h0BADF00D, 32'hFFFFFFFF, 32'h80000001, 32'h12345678}, {4{32'h5}}, {4{32'h7}});
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    lat = cyc - last_acc;
    chk_eq("latency_seen", seen, 1);
    chk_eq("latency", lat, 3);
    wait_drain();

    // thirds with rounding
    send(16'd1, 16'd2, 4'h3, 17'h5555, 17'h5555, 17'h5556,
         {4{32'd30}}, {4{32'd60}}, {4{32'hFFFFFFA6}});
    send(16'd3, 16'd4, 4'h5, 17'h5555, 17'h5555, 17'h5556,
         {4{32'd1}}, {4{32'd1}}, {4{32'd1}});
    // saturation both ways
    send(16'd5, 16'd6, 4'hF, 17'h10000, 17'h10000, 17'h10000,
         {4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}});
    send(16'd7, 16'd8, 4'hF, 17'h10000, 17'h10000, 17'h10000,
         {4{32'h80000000}}, {4{32'h80000000}}, {4{32'h80000000}});
    wait_drain();

    // backpressure: exactly QD accepted, then credit closes
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < QD; i++) send(16'(100 + i), 16'(i), 4'hF, 17'h8000, 17'h8000, 17'h0,
                                       {4{32'(i * 1000)}}, {4{32'(-i)}}, {4{32'd9}});
    in_valid = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) extra++;
    end
    chk_eq("bp_extra_accepts", extra, 0);
    chk_eq("bp_level_full", level, QD);
    chk_eq("bp_in_ready", in_ready, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk_eq("bp_drain_count", n_out - n0, QD);

    // empty-mask quad is dropped
    n0 = n_out;
    send(16'd50, 16'd51, 4'hF, 17'h4000, 17'h4000, 17'h8000, {4{32'd400}}, {4{32'd800}}, {4{32'd1200}});
    send(16'd52, 16'd53, 4'h0, 17'h4000, 17'h4000, 17'h8000, {4{32'd1}}, {4{32'd2}}, {4{32'd3}});
    send(16'd54, 16'd55, 4'hF, 17'h1, 17'h2, 17'h3, {4{32'hFFFF0000}}, {4{32'h10000}}, {4{32'h3}});
    wait_drain();
    chk_eq("drop_out_count", n_out - n0, 2);

    // flush with two in FIFO and one in S2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(200 + i), 16'd0, 4'hF, 17'h10000, 17'h0, 17'h0,
                                      {4{32'(i + 1)}}, {4{32'd0}}, {4{32'd0}});
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk_eq("pre_flush_level", level, 2);
    chk_eq("pre_flush_busy", busy, 1);
    chk_eq("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_eq("flush_level", level, 0);
    chk_eq("flush_busy", busy, 0);
    chk_eq("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("flush_no_late_out", out_valid, 0);
    @(posedge clk); #1;

    // reset in the middle of traffic
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    @(negedge clk);
    chk_eq("midrst_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_level", level, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_in_ready_after", in_ready, 1);
    chk_eq("midrst_out_word", {out_x, out_y, out_mask, out_attr}, 0);
    @(posedge clk); #1;

    // randomized stream with random consumer stalls
    rnd_on = 1;
    for (int i = 0; i < 30; i++) send_rand();
    rnd_on = 0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    chk_eq("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
